// File: rtl/srff_arb.sv
// srff_arb: round-robin arbiter giving NREQ requesters single-bit set/reset access to a shared SR flag bank.
// Optional macro SRFF_ARB_TOGGLE_EN enables opcode 11 as toggle; without it opcode 11 is rejected with ERR.

module srff_arb #(
  parameter int NREQ  = 4,
  parameter int NBITS = 8
) (
  input  logic                          CLK,
  input  logic                          CLR,
  input  logic [NREQ-1:0]               REQ,
  input  logic [2*NREQ-1:0]             OP,
  input  logic [$clog2(NBITS)*NREQ-1:0] ADDR,
  output logic [NREQ-1:0]               ACK,
  output logic [2:0]                    GNT_ID,
  output logic                          BUSY,
  output logic                          ERR,
  output logic [NBITS-1:0]              Q,
  output logic [NBITS-1:0]              QN
);

  localparam int AW = $clog2(NBITS);
  localparam int PW = $clog2(NREQ);
`ifdef SRFF_ARB_TOGGLE_EN
  localparam bit TOGGLE = 1'b1;
`else
  localparam bit TOGGLE = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, ARB = 2'd1, APPLY = 2'd2, ACKW = 2'd3} state_t;

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [1:0]      op_lat;
  logic [NREQ-1:0] req_rot;
  logic            found;
  int              win;
  logic [2:0]      win_id;
  logic [1:0]      op_w;
  logic [AW-1:0]   addr_w;
  logic            set_w;
  logic            rst_w;
  logic            req_gnt;

  // Rotate so bit 0 is the requester at ptr; the first set bit wins.
  always_comb begin
    req_rot = NREQ'({REQ, REQ} >> ptr);
    found   = 1'b0;
    win     = 0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req_rot[k]) begin
        found = 1'b1;
        win   = int'(ptr) + k;
      end
    end
    if (win >= NREQ) win = win - NREQ;
    win_id = 3'(win);
  end

  always_comb begin
    op_w    = 2'b00;
    addr_w  = '0;
    req_gnt = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_id == 3'(i)) begin
        op_w   = OP[2*i +: 2];
        addr_w = ADDR[AW*i +: AW];
      end
      if (GNT_ID == 3'(i)) req_gnt = REQ[i];
    end
    // S and R decodes are mutually exclusive by construction.
    set_w = (op_w == 2'b10) || (TOGGLE && (op_w == 2'b11) && !Q[addr_w]);
    rst_w = (op_w == 2'b01) || (TOGGLE && (op_w == 2'b11) &&  Q[addr_w]);
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state  <= IDLE;
      ptr    <= '0;
      op_lat <= 2'b00;
      GNT_ID <= 3'd0;
      ACK    <= '0;
      ERR    <= 1'b0;
      Q      <= '0;
    end else begin
      ERR <= 1'b0;
      case (state)
        IDLE: if (|REQ) state <= ARB;
        ARB: begin
          if (found) begin
            GNT_ID <= win_id;
            op_lat <= op_w;
            // Bank write commits on the edge entering APPLY, so Q is visible one edge before ACK.
            if (set_w)      Q[addr_w] <= 1'b1;
            else if (rst_w) Q[addr_w] <= 1'b0;
            state <= APPLY;
          end else begin
            state <= IDLE;
          end
        end
        APPLY: begin
          for (int i = 0; i < NREQ; i++) ACK[i] <= (GNT_ID == 3'(i));
          ERR   <= !TOGGLE && (op_lat == 2'b11);
          state <= ACKW;
        end
        ACKW: begin
          if (!req_gnt) begin
            ACK   <= '0;
            ptr   <= (GNT_ID == 3'(NREQ-1)) ? '0 : PW'(GNT_ID + 3'd1);
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign BUSY = (state != IDLE);
  assign QN   = ~Q;

endmodule

// File: doc/srff_arb.md
SRFF_ARB -- requirements
Module: srff_arb

Interface
REQ-001 SHALL provide parameter NREQ, default 4: number of requesters, 2..8.
REQ-002 SHALL provide parameter NBITS, default 8: number of SR flag bits in the shared bank, power of two, 2..16.
REQ-003 SHALL provide port CLK, input, 1: sole clock; all state changes on its rising edge.
REQ-004 SHALL provide port CLR, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL provide port REQ, input, NREQ: per-requester request level.
REQ-006 SHALL provide port OP, input, 2*NREQ: per-requester opcode, field i = OP[2i+1:2i]; 00 hold, 01 reset, 10 set, 11 toggle.
REQ-007 SHALL provide port ADDR, input, log2(NBITS)*NREQ: per-requester target bit index, field i in slice i.
REQ-008 SHALL provide port ACK, output, NREQ: per-requester acknowledge level.
REQ-009 SHALL provide port GNT_ID, output, 3: index of the current or last granted requester.
REQ-010 SHALL provide port BUSY, output, 1: high in every state except IDLE.
REQ-011 SHALL provide port ERR, output, 1: one-cycle pulse for a rejected opcode.
REQ-012 SHALL provide ports Q and QN, outputs, NBITS each: flag bank contents; QN is always the bitwise inverse of Q.

Function
REQ-013 SHALL implement a four-state FSM: IDLE, ARB, APPLY, ACKW.
REQ-014 IDLE: when any REQ bit is high at an edge, SHALL move to ARB; otherwise SHALL stay in IDLE.
REQ-015 ARB: SHALL select the winner round-robin, searching from pointer PTR upward modulo NREQ.
REQ-016 ARB: SHALL register the winner's index, OP and ADDR, drive GNT_ID with the index, and move to APPLY.
REQ-017 ARB: if REQ has fallen to all-zero, SHALL return to IDLE with no grant and no pointer change.
REQ-018 APPLY: SHALL update exactly one bank bit Q[ADDR] from the latched fields, then move to ACKW.
REQ-019 APPLY update rules: 01 sets the bit to 0; 10 sets it to 1; 00 leaves it unchanged. The bank SHALL never see S and R asserted together.
REQ-020 ACKW: SHALL hold ACK[GNT_ID] high until REQ[GNT_ID] is sampled low (4-phase handshake).
REQ-021 ACKW exit: SHALL drop ACK, set PTR = (GNT_ID+1) mod NREQ, and move to IDLE on that edge.
REQ-022 Latency: REQ rising before edge n in IDLE SHALL produce ACK high after edge n+2 and the Q update after edge n+1.
REQ-023 Requesters SHALL hold OP and ADDR stable from REQ rise until ACK; the controller samples them only in ARB.
REQ-024 Bits outside ADDR SHALL be unchanged. No two ACK bits SHALL ever be high together.
REQ-025 Requests arriving while BUSY SHALL wait and SHALL NOT be lost or reordered out of round-robin order.
REQ-026 Fairness: with all NREQ requesters continuously requesting, each SHALL be granted exactly once per NREQ grants.

Reset
REQ-027 While CLR=0, SHALL force Q=0, QN=all ones, ACK=0, ERR=0, BUSY=0, GNT_ID=0, PTR=0, state IDLE, independent of CLK.
REQ-028 Reset asserted in ARB or APPLY SHALL abort the operation, leaving Q at its reset value, with no ACK issued.
REQ-029 After CLR rises, the first evaluated edge SHALL be an IDLE edge.

Configuration
REQ-030 Macro SRFF_ARB_TOGGLE_EN: when defined, OP=11 SHALL invert Q[ADDR] in APPLY and ERR SHALL stay 0.
REQ-031 Macro SRFF_ARB_TOGGLE_EN: when undefined, OP=11 SHALL leave the bank unchanged, pulse ERR high for the APPLY-exit cycle, and still complete the ACK handshake.

Verification
REQ-032 Reset then single request: CLR low, then REQ=0001 with OP0=10, ADDR0=3 -> Q=0x08 after edge n+1, ACK=0001 after edge n+2, BUSY high from ARB through ACKW.
REQ-033 Set/reset sequence: requester 2 issues set bit 5, then reset bit 5 -> Q goes 0x20, then back to 0x00; QN is the inverse at every edge.
REQ-034 Contention: REQ=1111 held, each requester setting its own bit 0..3 -> GNT_ID sequence 0,1,2,3,0; Q=0x0F after four grants.
REQ-035 Toggle opcode: OP=11, ADDR=7 on Q=0x00 -> Q=0x80, ERR=0 with SRFF_ARB_TOGGLE_EN; Q=0x00 and one ERR pulse without it.
REQ-036 Mid-operation reset: CLR pulsed low while in APPLY with a set of bit 1 -> Q=0x00, ACK=0, FSM in IDLE, PTR=0.
REQ-037 Handshake hold: requester keeps REQ high 5 cycles after ACK -> ACK stays high 5 cycles, no other grant is issued, and the next grant follows REQ release.
